cordic_angle_sequencer: RTL and testbench
=========================================

// Module: cordic_angle_sequencer
// PURPOSE
//  Steps a CORDIC datapath through its iterations: per step emits the shift amount and the signed
//  angle constant (atan(2^-i) circular, atanh(2^-i) hyperbolic). Handles hyperbolic repeat steps
//  (i=4,13) and back-pressure. Sits between the CORDIC control FSM and the rotate/vector datapath.
// PARAMETERS
//  FIXED_WIDTH  16  angle output width, signed two's complement
//  FRAC_BITS    13  fractional bits of angle output (atanh(0.5) -> 16'h1194)
//  ITERATIONS   16  steps emitted per run, both modes (2..32)
// PORTS
//  clk        in   1                        clock, rising edge
//  rst_n      in   1                        reset, asynchronous, active-low
//  start      in   1                        begin a run; sampled only in IDLE
//  mode       in   2                        00 circular, 01 hyperbolic, 10 linear (opt), 11 illegal
//  abort      in   1                        terminate current run
//  step_ready in   1                        datapath consumes current step
//  step_valid out  1                        shift_amt/angle_out/last valid
//  shift_amt  out  $clog2(ITERATIONS+1)     right-shift for this step
//  angle_out  out  FIXED_WIDTH              signed angle constant for this step
//  last       out  1                        final step of run
//  busy       out  1                        not IDLE
//  err        out  1                        one-cycle pulse: start with illegal mode
// BEHAVIOUR
//  - Reset: step_valid=0, shift_amt=0, angle_out=0, last=0, busy=0, err=0; state IDLE.
//  - States IDLE -> RUN -> IDLE. start&&legal mode in IDLE: latch mode, next cycle RUN with
//    step_valid=1 and step 0 presented (latency 1 clk). All outputs registered.
//  - Step advance on step_valid&&step_ready; outputs hold stable while step_valid&&!step_ready.
//  - Circular: shifts 0,1,..,ITERATIONS-1. Hyperbolic: shifts start at 1, shifts 4 and 13
//    emitted twice (if reached), total ITERATIONS steps (16 -> 1,2,3,4,4,5..13,13,14).
//  - last=1 on step ITERATIONS-1; its handshake -> IDLE, step_valid=0 same edge; busy drops.
//  - Angle = ROM value for shift <= 15; above: 2^(FRAC_BITS-shift) (small-angle approx);
//    0 when shift > FRAC_BITS. ROM held at 24 fractional bits, rounded half-up to FRAC_BITS.
//  - Hyperbolic shift 0 never produced (atanh(1) undefined).
//  - start while busy ignored. abort: next edge -> IDLE, step_valid=0; abort wins over
//    simultaneous handshake and over start. abort in IDLE no effect.
//  - Illegal mode start: stay IDLE, err=1 for one cycle.
//  - rst_n low mid-run: immediate return to reset values, no step emitted.
// CONFIGURATION
//  - CORDIC_SEQ_LINEAR_EN defined: mode 10 legal; shifts 0..ITERATIONS-1, angle=2^(FRAC_BITS-shift)
//    (0 beyond FRAC_BITS), for multiply/divide.
//  - Undefined: mode 10 illegal (err pulse, start ignored), same as 11.
// STRUCTURE
//  - cordic_pkg: mode encodings (MODE_CIRC/HYP/LIN), ROM tables atan/atanh at Q0.24, repeat
//    indices (4,13), rounding function.
//  - Sub-module cordic_angle_rom: combinational (mode, shift) -> angle_out; incl. approx/zero.
//  - Top: FSM, step counter, shift counter with repeat flag, output registers.
// TESTING (FIXED_WIDTH=16, FRAC_BITS=13, ITERATIONS=16)
//  - Circular, ready=1: 16 steps, shifts 0..15; step0 angle 16'h1922, step1 16'h0ED6; last on 15.
//  - Hyperbolic, ready=1: shifts 1,2,3,4,4,5..13,13,14; step0 16'h1194; steps 3,4 both 16'h0201.
//  - Back-pressure: ready low 5 clks at step 2 -> outputs frozen, no skipped/duplicated step.
//  - abort at step 6 with ready=1 -> next clk step_valid=0, busy=0; fresh start runs from step 0.
//  - start mode=11 -> err one cycle, busy stays 0; mode=10 same unless CORDIC_SEQ_LINEAR_EN
//    (then step3 angle 16'h0400).
//  - rst_n low mid-run (async, between edges) -> all outputs 0 immediately; start while busy ignored.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC sequencer definitions: mode encodings, Q0.24 angle tables,
// hyperbolic repeat indices and the Q0.24 -> output-format rounding helper.
package cordic_pkg;

  typedef enum logic [1:0] {
    MODE_CIRC = 2'b00,
    MODE_HYP  = 2'b01,
    MODE_LIN  = 2'b10,
    MODE_ILL  = 2'b11
  } cordic_mode_e;

  localparam int ROM_FRAC  = 24;
  localparam int ROM_DEPTH = 16;
  localparam int REP_IDX0  = 4;
  localparam int REP_IDX1  = 13;

  // round(atan(2^-i) * 2^24)
  localparam logic [31:0] ATAN_Q24 [ROM_DEPTH] = '{
    32'd13176795, 32'd7778716, 32'd4110060, 32'd2086331,
    32'd1047214,  32'd524117,  32'd262123,  32'd131069,
    32'd65536,    32'd32768,   32'd16384,   32'd8192,
    32'd4096,     32'd2048,    32'd1024,    32'd512
  };

  // round(atanh(2^-i) * 2^24); entry 0 is never addressed
  localparam logic [31:0] ATANH_Q24 [ROM_DEPTH] = '{
    32'd0,        32'd9215828, 32'd4285116, 32'd2108178,
    32'd1049945,  32'd524459,  32'd262165,  32'd131075,
    32'd65536,    32'd32768,   32'd16384,   32'd8192,
    32'd4096,     32'd2048,    32'd1024,    32'd512
  };

  // Half-up rounding of a Q0.24 value down to frac_bits fractional bits.
  function automatic int round_q24(input logic [31:0] raw, input int frac_bits);
    int sh;
    logic [31:0] half;
    sh = ROM_FRAC - frac_bits;
    if (sh <= 0) return int'(raw);
    half = 32'd1 << (sh - 1);
    return int'((raw + half) >> sh);
  endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// Combinational angle lookup: (mode, shift) -> signed angle constant, using the
// tables for small shifts and the 2^-shift small-angle form elsewhere.
module cordic_angle_rom
  import cordic_pkg::*;
#(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 13,
  parameter int SHIFT_W     = 5
) (
  input  cordic_mode_e                   mode,
  input  logic         [SHIFT_W-1:0]     shift,
  output logic signed  [FIXED_WIDTH-1:0] angle
);

  int sh;
  int val;

  always_comb begin
    sh  = int'(shift);
    val = 0;
    if (mode == MODE_LIN || sh >= ROM_DEPTH) begin
      if (sh <= FRAC_BITS) val = 1 << (FRAC_BITS - sh);
    end else if (mode == MODE_HYP) begin
      val = round_q24(ATANH_Q24[sh[3:0]], FRAC_BITS);
    end else begin
      val = round_q24(ATAN_Q24[sh[3:0]], FRAC_BITS);
    end
    angle = FIXED_WIDTH'(val);
  end

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Steps a CORDIC datapath through its iterations, presenting shift and angle per step.
// Define CORDIC_SEQ_LINEAR_EN to make mode 2'b10 (linear) a legal run mode.
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 13,
  parameter int ITERATIONS  = 16,
  localparam int SHIFT_W    = $clog2(ITERATIONS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic        [1:0]             mode,
  input  logic                          abort,
  input  logic                          step_ready,
  output logic                          step_valid,
  output logic        [SHIFT_W-1:0]     shift_amt,
  output logic signed [FIXED_WIDTH-1:0] angle_out,
  output logic                          last,
  output logic                          busy,
  output logic                          err
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [SHIFT_W-1:0] LAST_STEP = SHIFT_W'(ITERATIONS - 1);

  state_e                          state_q, state_d;
  cordic_mode_e                    mode_q, mode_d;
  logic         [SHIFT_W-1:0]      step_q, step_d;
  logic         [SHIFT_W-1:0]      shift_d;
  logic                            rep_q, rep_d;
  logic                            vld_d, last_d, err_d, load;
  logic                            mode_legal;
  logic signed  [FIXED_WIDTH-1:0]  rom_angle;

`ifdef CORDIC_SEQ_LINEAR_EN
  assign mode_legal = (mode != MODE_ILL);
`else
  assign mode_legal = (mode == MODE_CIRC) || (mode == MODE_HYP);
`endif

  // Next step selection; the ROM sees the step about to be registered.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    step_d  = step_q;
    shift_d = shift_amt;
    rep_d   = rep_q;
    vld_d   = step_valid;
    last_d  = last;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_legal) begin
            mode_d  = cordic_mode_e'(mode);
            state_d = S_RUN;
            step_d  = '0;
            shift_d = (mode_d == MODE_HYP) ? SHIFT_W'(1) : '0;
            rep_d   = 1'b0;
            vld_d   = 1'b1;
            last_d  = 1'b0;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort || (step_ready && last)) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end else if (step_ready) begin
          step_d = step_q + 1'b1;
          last_d = (step_d == LAST_STEP);
          load   = 1'b1;
          // Hyperbolic convergence needs shifts 4 and 13 applied twice.
          if (mode_q == MODE_HYP && !rep_q &&
              (int'(shift_amt) == REP_IDX0 || int'(shift_amt) == REP_IDX1)) begin
            rep_d = 1'b1;
          end else begin
            rep_d   = 1'b0;
            shift_d = shift_amt + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  cordic_angle_rom #(
    .FIXED_WIDTH (FIXED_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .SHIFT_W     (SHIFT_W)
  ) u_rom (
    .mode  (mode_d),
    .shift (shift_d),
    .angle (rom_angle)
  );

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_CIRC;
      step_q     <= '0;
      rep_q      <= 1'b0;
      step_valid <= 1'b0;
      shift_amt  <= '0;
      angle_out  <= '0;
      last       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      rep_q      <= rep_d;
      step_valid <= vld_d;
      shift_amt  <= shift_d;
      last       <= last_d;
      busy       <= (state_d == S_RUN);
      err        <= err_d;
      if (load) angle_out <= rom_angle;
    end
  end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Bench for cordic_angle_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based model of the step sequence.
module tb_cordic_angle_sequencer;

  localparam int FW = 16;
  localparam int FB = 13;
  localparam int IT = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [1:0]             mode = 2'b00;
  logic                   abort = 1'b0;
  logic                   step_ready = 1'b0;
  logic                   step_valid;
  logic [$clog2(IT+1)-1:0] shift_amt;
  logic signed [FW-1:0]   angle_out;
  logic                   last;
  logic                   busy;
  logic                   err;

  always #5 clk = ~clk;

  cordic_angle_sequencer #(
    .FIXED_WIDTH (FW),
    .FRAC_BITS   (FB),
    .ITERATIONS  (IT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .shift_amt  (shift_amt),
    .angle_out  (angle_out),
    .last       (last),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    int shift;
    int angle;
  } step_t;

  step_t exp_q[$];
  bit    m_busy = 1'b0;
  bit    m_err  = 1'b0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Angle from real-valued math: Q0.24 nearest, then half-up to FB bits.
  function automatic int ref_angle(input int md, input int s);
    real x, a;
    int  q24;
    if (md == 2 || s > 15) return (s > FB) ? 0 : (1 << (FB - s));
    x = 1.0;
    for (int k = 0; k < s; k++) x = x / 2.0;
    if (md == 1) a = 0.5 * $ln((1.0 + x) / (1.0 - x));
    else         a = $atan(x);
    q24 = $rtoi(a * 16777216.0 + 0.5);
    return (q24 + (1 << (23 - FB))) >>> (24 - FB);
  endfunction

  function automatic bit legal(input int md);
    if (md == 0 || md == 1) return 1'b1;
`ifdef CORDIC_SEQ_LINEAR_EN
    if (md == 2) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic build_run(input int md);
    step_t e;
    int s;
    exp_q.delete();
    if (md == 1) begin
      s = 1;
      while (exp_q.size() < IT) begin
        e.shift = s; e.angle = ref_angle(md, s);
        exp_q.push_back(e);
        if ((s == 4 || s == 13) && exp_q.size() < IT) exp_q.push_back(e);
        s++;
      end
    end else begin
      for (int i = 0; i < IT; i++) begin
        e.shift = i; e.angle = ref_angle(md, i);
        exp_q.push_back(e);
      end
    end
  endtask

  // Reference model: front of exp_q is the step currently presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_busy) begin
        if (abort) begin
          exp_q.delete();
          m_busy = 1'b0;
        end else if (step_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_busy = 1'b0;
        end
      end else if (start) begin
        if (legal(int'(mode))) begin
          build_run(int'(mode));
          m_busy = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("step_valid", int'(step_valid), int'(m_busy));
    chk("busy", int'(busy), int'(m_busy));
    chk("err", int'(err), int'(m_err));
    if (m_busy && exp_q.size() > 0) begin
      chk("shift_amt", int'(shift_amt), exp_q[0].shift);
      chk("angle_out", int'(angle_out), exp_q[0].angle);
      chk("last", int'(last), int'(exp_q.size() == 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(input logic [1:0] md);
    mode  = md;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    // Model anchors against hand-derived constants
    chk("model_circ0", ref_angle(0, 0), 'h1922);
    chk("model_circ1", ref_angle(0, 1), 'h0ED6);
    chk("model_hyp1", ref_angle(1, 1), 'h1194);
    chk("model_hyp4", ref_angle(1, 4), 'h0201);
    chk("model_lin3", ref_angle(2, 3), 'h0400);

    cyc(3);
    chk("rst_shift", int'(shift_amt), 0);
    chk("rst_angle", int'(angle_out), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_valid", int'(step_valid), 0);
    rst_n = 1'b1;
    cyc(2);

    // Circular, always ready
    step_ready = 1'b1;
    launch(2'b00);
    #2; chk("circ_s0_angle", int'(angle_out), 'h1922); chk("circ_s0_shift", int'(shift_amt), 0);
    cyc(1);
    #2; chk("circ_s1_angle", int'(angle_out), 'h0ED6);
    cyc(14);
    #2; chk("circ_s15_shift", int'(shift_amt), 15); chk("circ_s15_last", int'(last), 1);
    cyc(1);
    #2; chk("circ_done_valid", int'(step_valid), 0); chk("circ_done_busy", int'(busy), 0);
    cyc(2);

    // Hyperbolic, always ready
    launch(2'b01);
    #2; chk("hyp_s0_angle", int'(angle_out), 'h1194); chk("hyp_s0_shift", int'(shift_amt), 1);
    cyc(3);
    #2; chk("hyp_s3_shift", int'(shift_amt), 4); chk("hyp_s3_angle", int'(angle_out), 'h0201);
    cyc(1);
    #2; chk("hyp_s4_shift", int'(shift_amt), 4); chk("hyp_s4_angle", int'(angle_out), 'h0201);
    cyc(11);
    #2; chk("hyp_s15_shift", int'(shift_amt), 14); chk("hyp_s15_last", int'(last), 1);
    cyc(3);

    // Back-pressure at step 2
    launch(2'b00);
    cyc(2);
    step_ready = 1'b0;
    cyc(5);
    #2; chk("bp_frozen_shift", int'(shift_amt), 2); chk("bp_frozen_valid", int'(step_valid), 1);
    step_ready = 1'b1;
    cyc(1);
    #2; chk("bp_resume_shift", int'(shift_amt), 3);
    cyc(16);

    // Abort at step 6, restart, then start while busy
    launch(2'b00);
    cyc(6);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    #2; chk("abort_valid", int'(step_valid), 0); chk("abort_busy", int'(busy), 0);
    launch(2'b00);
    #2; chk("restart_shift", int'(shift_amt), 0); chk("restart_valid", int'(step_valid), 1);
    cyc(3);
    mode = 2'b01; start = 1'b1;
    cyc(1);
    start = 1'b0; mode = 2'b00;
    #2; chk("busy_start_shift", int'(shift_amt), 4);
    cyc(16);

    // Illegal / optional modes
    launch(2'b11);
    #2; chk("ill11_err", int'(err), 1); chk("ill11_busy", int'(busy), 0);
    cyc(1);
    #2; chk("ill11_err_clr", int'(err), 0);
    launch(2'b10);
`ifdef CORDIC_SEQ_LINEAR_EN
    cyc(3);
    #2; chk("lin_s3_angle", int'(angle_out), 'h0400); chk("lin_s3_shift", int'(shift_amt), 3);
`else
    #2; chk("ill10_err", int'(err), 1); chk("ill10_busy", int'(busy), 0);
`endif
    cyc(20);

    // Asynchronous reset between edges mid-run
    launch(2'b01);
    cyc(4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(step_valid), 0); chk("arst_busy", int'(busy), 0);
    chk("arst_shift", int'(shift_amt), 0); chk("arst_angle", int'(angle_out), 0);
    chk("arst_last", int'(last), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 6) == 0;
      mode       = 2'($urandom % 4);
      step_ready = ($urandom % 4) != 0;
      abort      = ($urandom % 40) == 0;
      cyc(1);
    end
    start = 1'b0; abort = 1'b0; step_ready = 1'b1;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
